muxn_rr: RTL and testbench
==========================

# muxn_rr

Parametrised N-channel stream multiplexer with round-robin arbitration, packet locking and a registered output stage. Generalises the combinational 2:1/4:1 selectors to any width and channel count. Selection is internal, not an external select bus. Sits between several packet producers and a single consumer that exerts backpressure via valid/ready.

## Interface
- Size, 8, data width per channel in bits (≥1)
- N, 4, number of input channels (≥2, need not be a power of 2)
- SW, $clog2(N), select/pointer width (derived, not overridden)

- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous and active-low
- in_valid  input  N  per-channel beat valid
- in_last  input  N  per-channel end-of-packet flag, qualified by in_valid
- in_data  input  N*Size  channel k at bits [k*Size +: Size]
- in_ready  output  N  per-channel accept; at most one bit high in any cycle
- out_valid  output  1  registered beat valid
- out_last  output  1  registered end-of-packet flag
- out_data  output  Size  registered beat data
- out_sel  output  SW  channel index of the beat on out_data
- out_ready  input  1  consumer accept

## Operation
- Transfer on channel k: in_valid[k] & in_ready[k] at a clk edge. Output transfer: out_valid & out_ready.
- load = ~out_valid | out_ready. No channel gets in_ready unless load=1.
- State IDLE (no packet open) and LOCK (packet open on channel grant).
- IDLE: pick = first k with in_valid[k], searching ptr, ptr+1, …, N-1, 0, …, ptr-1. in_ready[pick]=load. No valid channel → in_ready all 0.
- IDLE transfer with in_last=1: stay IDLE, ptr ← (pick+1) mod N.
- IDLE transfer with in_last=0: → LOCK, grant ← pick.
- LOCK: only in_ready[grant]=load. Other channels wait regardless of in_valid.
- LOCK transfer with in_last=1: → IDLE, ptr ← (grant+1) mod N. in_last=0 keeps LOCK.
- Pointer wrap: when grant=N-1, ptr becomes 0. Non-power-of-2 N must never produce ptr ≥ N.
- On any input transfer the output regs take the beat: out_data, out_last, out_sel ← channel data, last, index; out_valid ← 1.
- load=1 with no input transfer: out_valid ← 0. out_data, out_last and out_sel hold their values.
- Stall (out_valid & ~out_ready): all output regs hold, no input accepted, state and ptr hold.
- Reset, asynchronous at any time including mid-packet: state IDLE, ptr 0, grant 0, out_valid 0, out_last 0, out_data 0, out_sel 0. in_ready is all 0 while rst_n=0. An open packet is abandoned; the consumer sees no further beats of it.

## Timing
- Latency: input transfer at edge t gives the beat on the output from t to t+1.
- Throughput: one beat per cycle with out_ready held high, including back-to-back packets from different channels. No idle cycle is inserted on a grant change.
- in_ready is combinational from state, ptr, in_valid and out_ready. It has no combinational dependency on in_data or in_last, except through the state update at the next edge.
- A producer must hold in_valid, in_data and in_last stable until accepted. The block must not rely on this holding for correctness of other channels.
- Simultaneous output drain and input accept in the same cycle is legal and required: out_valid=1, out_ready=1 and a new transfer in one cycle.

## Structure
- Shared package/header muxn_defs:
  - state encoding constants ST_IDLE=1'b0, ST_LOCK=1'b1
  - clog2 helper, if the tool flow lacks $clog2
- Sub-module muxn_rr_pick:
  - combinational round-robin priority picker
  - inputs: request vector [N-1:0], ptr [SW-1:0]
  - outputs: pick index [SW-1:0], any
  - instantiated once
- Data selection: indexed part-select on in_data, no per-channel register.

## Test plan
- Reset mid-packet: N=4, Size=8. Ch2 sends 0x11 (last=0), then assert rst_n=0 for 1 cycle → out_valid=0, out_data=0x00 immediately; after release ch0 single-beat 0xA0 → out_sel=0, ptr=1.
- Round-robin fairness: all 4 channels continuously valid with single-beat packets, out_ready=1 → out_sel sequence 0,1,2,3,0,1… one beat per cycle, no gaps.
- Packet lock: ch1 sends 3 beats 0x21,0x22,0x23(last) while ch0, ch3 valid → output 0x21,0x22,0x23 with out_sel=1 consecutive; next grant ch3 (ptr=2 → first valid from 2); in_ready[0], in_ready[3] stay 0 during lock.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 → out_data/out_last/out_sel stable, in_ready all 0; on out_ready=1 the drain and next accept happen in the same cycle.
- Non-power-of-2 wrap: N=3, only ch2 then ch0 valid → after ch2's last beat ptr=0, ch0 granted; ptr never reaches 3.
- Idle gap: single beat accepted, then no in_valid with out_ready=1 → out_valid drops after 1 cycle, out_data holds its last value.

Source files
------------

// File: rtl/muxn_rr_pkg.sv
// ===========================================================================
// muxn_rr_pkg : shared state encoding for the round-robin stream multiplexer
// Revision 1.0 : initial release
// ===========================================================================
`default_nettype none

package muxn_rr_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/muxn_rr_pick.sv
// ===========================================================================
// muxn_rr_pick : combinational round-robin priority picker (ptr first, wrap)
// Revision 1.0 : initial release
// ===========================================================================
`default_nettype none

module muxn_rr_pick #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] pick,
  output logic          any
);

  int            w_idx;
  logic [SW-1:0] w_sel;

  // Scan from the farthest offset back to ptr so the nearest request wins.
  always_comb begin
    pick  = '0;
    any   = 1'b0;
    w_idx = 0;
    w_sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_idx = int'(ptr) + i;
      if (w_idx >= N) w_idx = w_idx - N;
      w_sel = SW'(w_idx);
      if (req[w_sel]) begin
        pick = w_sel;
        any  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/muxn_rr.sv
// ===========================================================================
// muxn_rr : N-channel stream mux, round-robin arbitration, packet locking
// Revision 1.0 : initial release
// ===========================================================================
`default_nettype none

module muxn_rr
  import muxn_rr_pkg::*;
#(
  parameter int Size = 8,
  parameter int N    = 4,
  parameter int SW   = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      in_valid,
  input  logic [N-1:0]      in_last,
  input  logic [N*Size-1:0] in_data,
  output logic [N-1:0]      in_ready,
  output logic              out_valid,
  output logic              out_last,
  output logic [Size-1:0]   out_data,
  output logic [SW-1:0]     out_sel,
  input  logic              out_ready
);

  state_t          r_state, w_state_nxt;
  logic [SW-1:0]   r_ptr, w_ptr_nxt;
  logic [SW-1:0]   r_grant, w_grant_nxt;
  logic [SW-1:0]   w_pick, w_chan, w_chan_inc;
  logic            w_any, w_load, w_en, w_xfer, w_chan_last;
  logic            r_out_valid, r_out_last;
  logic [Size-1:0] r_out_data;
  logic [SW-1:0]   r_out_sel;

  muxn_rr_pick #(.N(N), .SW(SW)) u_pick (
    .req  (in_valid),
    .ptr  (r_ptr),
    .pick (w_pick),
    .any  (w_any)
  );

  assign w_load      = ~r_out_valid | out_ready;
  assign w_chan      = (r_state == ST_LOCK) ? r_grant : w_pick;
  // Gated by rst_n so no producer sees ready while reset is held.
  assign w_en        = rst_n & w_load & ((r_state == ST_LOCK) | w_any);
  assign in_ready    = w_en ? (N'(1) << w_chan) : '0;
  assign w_xfer      = w_en & in_valid[w_chan];
  assign w_chan_last = in_last[w_chan];
  assign w_chan_inc  = (w_chan == SW'(N - 1)) ? '0 : w_chan + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_grant_nxt = r_grant;
    if (w_xfer) begin
      if (w_chan_last) begin
        w_state_nxt = ST_IDLE;
        w_ptr_nxt   = w_chan_inc;
      end else begin
        w_state_nxt = ST_LOCK;
        w_grant_nxt = w_chan;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_grant <= w_grant_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_last  <= w_chan_last;
      r_out_data  <= in_data[int'(w_chan) * Size +: Size];
      r_out_sel   <= w_chan;
    end else if (w_load) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule

`default_nettype wire

// File: tb/tb_muxn_rr.sv
// ===========================================================================
// tb_muxn_rr : directed vector bench for muxn_rr (N=4 and N=3 instances)
// Revision 1.0 : initial release
// ===========================================================================
`default_nettype none

module tb_muxn_rr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [3:0]  v4 = '0, l4 = '0, rdy4;
  logic [31:0] d4 = '0;
  logic        ordy4 = 1'b1, ov4, ol4;
  logic [7:0]  od4;
  logic [1:0]  sel4;

  logic [2:0]  v3 = '0, l3 = '0, rdy3;
  logic [23:0] d3 = '0;
  logic        ordy3 = 1'b1, ov3, ol3;
  logic [7:0]  od3;
  logic [1:0]  sel3;

  int n_checks = 0;
  int n_fail   = 0;

  muxn_rr #(.Size(8), .N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_last(l4), .in_data(d4),
    .in_ready(rdy4), .out_valid(ov4), .out_last(ol4), .out_data(od4),
    .out_sel(sel4), .out_ready(ordy4)
  );

  muxn_rr #(.Size(8), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_last(l3), .in_data(d3),
    .in_ready(rdy3), .out_valid(ov3), .out_last(ol3), .out_data(od3),
    .out_sel(sel3), .out_ready(ordy3)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic [7:0]  e_od;
    logic [1:0]  e_sel;
    logic        e_ol;
  } vec4_t;

  typedef struct packed {
    logic [2:0]  v;
    logic [2:0]  l;
    logic [23:0] d;
    logic [2:0]  e_rdy;
    logic [7:0]  e_od;
    logic [1:0]  e_sel;
    logic        e_ol;
  } vec3_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step4(input vec4_t t, input int k);
    v4 = t.v; l4 = t.l; d4 = t.d; ordy4 = t.ordy;
    @(negedge clk);
    check($sformatf("v%0d in_ready", k), 32'(rdy4), 32'(t.e_rdy));
    @(posedge clk); #1;
    check($sformatf("v%0d out_valid", k), 32'(ov4), 32'(t.e_ov));
    check($sformatf("v%0d out_data", k), 32'(od4), 32'(t.e_od));
    check($sformatf("v%0d out_sel", k), 32'(sel4), 32'(t.e_sel));
    check($sformatf("v%0d out_last", k), 32'(ol4), 32'(t.e_ol));
  endtask

  task automatic step3(input vec3_t t, input int k);
    v3 = t.v; l3 = t.l; d3 = t.d;
    @(negedge clk);
    check($sformatf("n3 v%0d in_ready", k), 32'(rdy3), 32'(t.e_rdy));
    @(posedge clk); #1;
    check($sformatf("n3 v%0d out_valid", k), 32'(ov3), 32'd1);
    check($sformatf("n3 v%0d out_data", k), 32'(od3), 32'(t.e_od));
    check($sformatf("n3 v%0d out_sel", k), 32'(sel3), 32'(t.e_sel));
    check($sformatf("n3 v%0d out_last", k), 32'(ol3), 32'(t.e_ol));
  endtask

  vec4_t tab4[$];
  vec3_t tab3[$];

  initial begin
    // ch3/ch2/ch1/ch0 bytes packed MSB first in d
    tab4.push_back('{4'b1111, 4'b1111, 32'hB3B2B1B0, 1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1, 1'b1});
    tab4.push_back('{4'b1111, 4'b1111, 32'hB3B2B1B0, 1'b1, 4'b0100, 1'b1, 8'hB2, 2'd2, 1'b1});
    tab4.push_back('{4'b1111, 4'b1111, 32'hB3B2B1B0, 1'b1, 4'b1000, 1'b1, 8'hB3, 2'd3, 1'b1});
    tab4.push_back('{4'b1111, 4'b1111, 32'hB3B2B1B0, 1'b1, 4'b0001, 1'b1, 8'hB0, 2'd0, 1'b1});
    // ch1 three-beat packet while ch0/ch3 wait
    tab4.push_back('{4'b1011, 4'b1001, 32'h3300210F, 1'b1, 4'b0010, 1'b1, 8'h21, 2'd1, 1'b0});
    tab4.push_back('{4'b1011, 4'b1001, 32'h3300220F, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1, 1'b0});
    tab4.push_back('{4'b1011, 4'b1011, 32'h3300230F, 1'b1, 4'b0010, 1'b1, 8'h23, 2'd1, 1'b1});
    tab4.push_back('{4'b1001, 4'b1001, 32'h3300000F, 1'b1, 4'b1000, 1'b1, 8'h33, 2'd3, 1'b1});
    // backpressure: five stalled cycles then drain + accept together
    for (int i = 0; i < 5; i++)
      tab4.push_back('{4'b0001, 4'b0001, 32'h000000C0, 1'b0, 4'b0000, 1'b1, 8'h33, 2'd3, 1'b1});
    tab4.push_back('{4'b0001, 4'b0001, 32'h000000C0, 1'b1, 4'b0001, 1'b1, 8'hC0, 2'd0, 1'b1});
    // idle gap
    tab4.push_back('{4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'hC0, 2'd0, 1'b1});
    tab4.push_back('{4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'hC0, 2'd0, 1'b1});

    // N=3: ch2 packet, then wrap to ch0, then rotation 1,2,0
    tab3.push_back('{3'b100, 3'b000, 24'h310000, 3'b100, 8'h31, 2'd2, 1'b0});
    tab3.push_back('{3'b100, 3'b100, 24'h320000, 3'b100, 8'h32, 2'd2, 1'b1});
    tab3.push_back('{3'b011, 3'b011, 24'h004140, 3'b001, 8'h40, 2'd0, 1'b1});
    tab3.push_back('{3'b111, 3'b111, 24'h525150, 3'b010, 8'h51, 2'd1, 1'b1});
    tab3.push_back('{3'b111, 3'b111, 24'h525150, 3'b100, 8'h52, 2'd2, 1'b1});
    tab3.push_back('{3'b111, 3'b111, 24'h525150, 3'b001, 8'h50, 2'd0, 1'b1});

    // reset state, with requests pending to confirm in_ready stays low
    v4 = 4'b1111; l4 = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", 32'(rdy4), 32'd0);
    check("rst out_valid", 32'(ov4), 32'd0);
    check("rst out_data", 32'(od4), 32'd0);
    check("rst out_sel", 32'(sel4), 32'd0);
    check("rst out_last", 32'(ol4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // mid-packet reset: ch2 opens a packet, then reset is pulsed
    step4('{4'b0100, 4'b0000, 32'h00110000, 1'b1, 4'b0100, 1'b1, 8'h11, 2'd2, 1'b0}, 100);
    #1 rst_n = 1'b0;
    #1;
    check("midrst out_valid", 32'(ov4), 32'd0);
    check("midrst out_data", 32'(od4), 32'd0);
    check("midrst in_ready", 32'(rdy4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step4('{4'b0001, 4'b0001, 32'h000000A0, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0, 1'b1}, 101);

    for (int i = 0; i < tab4.size(); i++) step4(tab4[i], i);
    for (int i = 0; i < tab3.size(); i++) step3(tab3[i], i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
